// File: rtl/vp_pkg.sv
`default_nettype none
// ==========================================================================
// Package : vp_pkg
// State encoding and helpers shared by the video-path crop/decimate blocks.
// Rev     : 1.0
// ==========================================================================
package vp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } crop_state_t;

    // ceil(val / 2^shift)
    function automatic int unsigned ceil_div_pow2(input int unsigned val,
                                                  input int unsigned shift);
        int unsigned unit;
        unit = 32'd1 << shift;
        return (val + unit - 32'd1) >> shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/image_crop_win_if.sv
`default_nettype none
// ==========================================================================
// Interface : image_crop_win_if
// Window config, input video stream and cropped output stream.
// Rev       : 1.0
// ==========================================================================
interface image_crop_win_if #(
    parameter int X_W    = 11,
    parameter int Y_W    = 11,
    parameter int DATA_W = 24,
    parameter int DEC_W  = 2
);
    logic [X_W-1:0]    start_x;
    logic [X_W-1:0]    end_x;
    logic [Y_W-1:0]    start_y;
    logic [Y_W-1:0]    end_y;
    logic [DEC_W-1:0]  dec_x;
    logic [DEC_W-1:0]  dec_y;
    logic              vs_i;
    logic              de_i;
    logic [DATA_W-1:0] data_i;
    logic              vs_o;
    logic              de_o;
    logic [DATA_W-1:0] data_o;
    logic              eol_o;
    logic              eof_o;
    logic              cfg_err_o;

    modport master (
        output start_x, end_x, start_y, end_y, dec_x, dec_y,
        output vs_i, de_i, data_i,
        input  vs_o, de_o, data_o, eol_o, eof_o, cfg_err_o
    );

    modport slave (
        input  start_x, end_x, start_y, end_y, dec_x, dec_y,
        input  vs_i, de_i, data_i,
        output vs_o, de_o, data_o, eol_o, eof_o, cfg_err_o
    );
endinterface
`default_nettype wire

// File: rtl/image_crop_win.sv
`default_nettype none
// ==========================================================================
// Module : image_crop_win
// Crop-and-decimate window; config shadowed on each vs_i rising edge.
// Rev    : 1.0
// ==========================================================================
module image_crop_win
    import vp_pkg::*;
#(
    parameter int H_DISP = 1280,
    parameter int V_DISP = 720,
    parameter int X_W    = 11,
    parameter int Y_W    = 11,
    parameter int DATA_W = 24,
    parameter int DEC_W  = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    image_crop_win_if.slave bus
);

    localparam int              XW1    = X_W + 1;
    localparam int              YW1    = Y_W + 1;
    localparam logic [X_W:0]    H_LIM  = XW1'(H_DISP);
    localparam logic [Y_W:0]    V_LIM  = YW1'(V_DISP);
    localparam logic [X_W-1:0]  X_LAST = X_W'(H_DISP - 1);
    localparam logic [Y_W-1:0]  Y_LAST = Y_W'(V_DISP - 1);

    crop_state_t       state;
    crop_state_t       state_n;
    logic              vs_d;

    logic [X_W-1:0]    sh_start_x;
    logic [X_W-1:0]    sh_end_x;
    logic [Y_W-1:0]    sh_start_y;
    logic [Y_W-1:0]    sh_end_y;
    logic [DEC_W-1:0]  sh_dec_x;
    logic [DEC_W-1:0]  sh_dec_y;
    logic [X_W-1:0]    out_w;
    logic [Y_W-1:0]    out_h;
    logic              cfg_err;

    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;

    logic              vs_out;
    logic              de_out;
    logic [DATA_W-1:0] data_out;
    logic              eol_out;
    logic              eof_out;

    logic              vs_rise;
    logic              cfg_bad;
    logic [X_W:0]      dx_cfg;
    logic [Y_W:0]      dy_cfg;
    logic [X_W-1:0]    out_w_n;
    logic [Y_W-1:0]    out_h_n;
    logic [X_W:0]      dx_pix;
    logic [Y_W:0]      dy_pix;
    logic [X_W:0]      mask_x;
    logic [Y_W:0]      mask_y;
    logic              in_win;
    logic              phase_ok;
    logic              pix_valid;
    logic              keep;
    logic              line_last;
    logic              frame_last;
    logic              out_line_last;
    logic              out_frame_last;

    assign vs_rise = bus.vs_i & ~vs_d;

    // Live config: validated and sized only at the frame-start edge
    assign dx_cfg  = {1'b0, bus.end_x} - {1'b0, bus.start_x};
    assign dy_cfg  = {1'b0, bus.end_y} - {1'b0, bus.start_y};
    assign cfg_bad = (bus.start_x >= bus.end_x) | (bus.start_y >= bus.end_y) |
                     ({1'b0, bus.end_x} > H_LIM) | ({1'b0, bus.end_y} > V_LIM);
    assign out_w_n = X_W'(ceil_div_pow2(32'(dx_cfg), 32'(bus.dec_x)));
    assign out_h_n = Y_W'(ceil_div_pow2(32'(dy_cfg), 32'(bus.dec_y)));

    // Pixel selection against the shadowed window
    assign dx_pix    = {1'b0, in_x} - {1'b0, sh_start_x};
    assign dy_pix    = {1'b0, in_y} - {1'b0, sh_start_y};
    assign mask_x    = (XW1'(1) << sh_dec_x) - XW1'(1);
    assign mask_y    = (YW1'(1) << sh_dec_y) - YW1'(1);
    assign in_win    = (in_x >= sh_start_x) & (in_x < sh_end_x) &
                       (in_y >= sh_start_y) & (in_y < sh_end_y);
    assign phase_ok  = ((dx_pix & mask_x) == '0) & ((dy_pix & mask_y) == '0);
    assign pix_valid = (state == ACTIVE) & bus.de_i;
    assign keep      = pix_valid & ~vs_rise & ~cfg_err & in_win & phase_ok;

    assign line_last      = (in_x == X_LAST);
    assign frame_last     = line_last & (in_y == Y_LAST);
    assign out_line_last  = (out_x == out_w - X_W'(1));
    assign out_frame_last = (out_y == out_h - Y_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (vs_rise) begin
            state_n = ACTIVE;
        end else if (pix_valid && frame_last) begin
            state_n = DONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d       <= 1'b0;
            sh_start_x <= '0;
            sh_end_x   <= '0;
            sh_start_y <= '0;
            sh_end_y   <= '0;
            sh_dec_x   <= '0;
            sh_dec_y   <= '0;
            out_w      <= '0;
            out_h      <= '0;
            cfg_err    <= 1'b0;
        end else begin
            vs_d <= bus.vs_i;
            if (vs_rise) begin
                sh_start_x <= bus.start_x;
                sh_end_x   <= bus.end_x;
                sh_start_y <= bus.start_y;
                sh_end_y   <= bus.end_y;
                sh_dec_x   <= bus.dec_x;
                sh_dec_y   <= bus.dec_y;
                out_w      <= out_w_n;
                out_h      <= out_h_n;
                cfg_err    <= cfg_bad;
            end
        end
    end

    // A frame-start edge wins over any pixel sampled in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_x  <= '0;
            in_y  <= '0;
            out_x <= '0;
            out_y <= '0;
        end else if (vs_rise) begin
            in_x  <= '0;
            in_y  <= '0;
            out_x <= '0;
            out_y <= '0;
        end else begin
            if (pix_valid) begin
                if (line_last) begin
                    in_x <= '0;
                    in_y <= frame_last ? '0 : in_y + Y_W'(1);
                end else begin
                    in_x <= in_x + X_W'(1);
                end
            end
            if (keep) begin
                if (out_line_last) begin
                    out_x <= '0;
                    out_y <= out_y + Y_W'(1);
                end else begin
                    out_x <= out_x + X_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_out   <= 1'b0;
            de_out   <= 1'b0;
            data_out <= '0;
            eol_out  <= 1'b0;
            eof_out  <= 1'b0;
        end else begin
            vs_out   <= vs_rise;
            de_out   <= keep;
            data_out <= keep ? bus.data_i : '0;
            eol_out  <= keep & out_line_last;
            eof_out  <= keep & out_line_last & out_frame_last;
        end
    end

    assign bus.vs_o      = vs_out;
    assign bus.de_o      = de_out;
    assign bus.data_o    = data_out;
    assign bus.eol_o     = eol_out;
    assign bus.eof_o     = eof_out;
    assign bus.cfg_err_o = cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_image_crop_win.sv
`default_nettype none
// ==========================================================================
// Module : tb_image_crop_win
// Directed frame-table bench for image_crop_win on a 16x8 raster.
// Rev    : 1.0
// ==========================================================================
module tb_image_crop_win;

    localparam int H   = 16;
    localparam int V   = 8;
    localparam int XW  = 11;
    localparam int YW  = 11;
    localparam int DW  = 24;
    localparam int DCW = 2;

    typedef struct {
        int         sx, ex, sy, ey, dx, dy;
        int         exp_n;
        logic [23:0] exp_first;
        logic [23:0] exp_eof;
        int         exp_eols;
        logic       exp_err;
    } frame_vec_t;

    typedef struct packed {
        logic [23:0] data;
        logic        eol;
        logic        eof;
    } pix_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    image_crop_win_if #(.X_W(XW), .Y_W(YW), .DATA_W(DW), .DEC_W(DCW)) bus ();

    image_crop_win #(
        .H_DISP(H), .V_DISP(V), .X_W(XW), .Y_W(YW), .DATA_W(DW), .DEC_W(DCW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   tests  = 0;
    int   failed = 0;

    // Monitor: cumulative capture so the stimulus side never writes these
    pix_t        cap[$];
    pix_t        mon_p;
    logic [23:0] prev_data;
    int          vs_cnt   = 0;
    int          lat_err  = 0;
    int          idle_err = 0;

    always @(posedge clk) prev_data <= bus.data_i;

    always @(negedge clk) begin
        if (bus.de_o) begin
            mon_p = '{bus.data_o, bus.eol_o, bus.eof_o};
            cap.push_back(mon_p);
            if (bus.data_o !== prev_data) lat_err++;
        end else if (bus.data_o !== '0 || bus.eol_o || bus.eof_o) begin
            idle_err++;
        end
        if (bus.vs_o) vs_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vs, input logic de, input logic [23:0] d);
        @(posedge clk);
        #1;
        bus.vs_i   = vs;
        bus.de_i   = de;
        bus.data_i = d;
    endtask

    task automatic set_cfg(input frame_vec_t v);
        bus.start_x = XW'(v.sx);
        bus.end_x   = XW'(v.ex);
        bus.start_y = YW'(v.sy);
        bus.end_y   = YW'(v.ey);
        bus.dec_x   = DCW'(v.dx);
        bus.dec_y   = DCW'(v.dy);
    endtask

    function automatic logic [23:0] pix(input int y, input int x);
        return {12'(y), 12'(x)};
    endfunction

    // Drives one whole frame and checks it against the table entry and a
    // loop-generated reference stream; optionally rewrites start_x mid-frame.
    task automatic run_frame(input frame_vec_t v, input string name,
                             input int chg_at, input int chg_sx);
        int   cb, vb, lb, ib, xs, ys, neol, neof, mism;
        logic [23:0] eof_data;
        pix_t p;
        pix_t exp_q[$];

        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        cb = cap.size(); vb = vs_cnt; lb = lat_err; ib = idle_err;
        set_cfg(v);

        // Edge cycle carries a junk pixel that must be dropped; vs held high
        drive(1'b1, 1'b1, 24'hABCDEF);
        drive(1'b1, 1'b0, '0);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        for (int y = 0; y < V; y++) begin
            for (int x = 0; x < H; x++) begin
                if (y * H + x == chg_at) bus.start_x = XW'(chg_sx);
                drive(1'b0, 1'b1, pix(y, x));
            end
            drive(1'b0, 1'b0, '0);
        end
        repeat (4) drive(1'b0, 1'b1, 24'h123456);
        drive(1'b0, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        @(negedge clk);

        exp_q.delete();
        if (!(v.sx >= v.ex || v.sy >= v.ey || v.ex > H || v.ey > V)) begin
            xs = 1 << v.dx;
            ys = 1 << v.dy;
            for (int y = v.sy; y < v.ey; y += ys) begin
                for (int x = v.sx; x < v.ex; x += xs) begin
                    p.data = pix(y, x);
                    p.eol  = (x + xs >= v.ex);
                    p.eof  = p.eol && (y + ys >= v.ey);
                    exp_q.push_back(p);
                end
            end
        end

        neol = 0; neof = 0; eof_data = '0; mism = 0;
        for (int i = cb; i < cap.size(); i++) begin
            if (cap[i].eol) neol++;
            if (cap[i].eof) begin neof++; eof_data = cap[i].data; end
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (cb + i >= cap.size() || cap[cb + i] !== exp_q[i]) mism++;
        end
        mism += (cap.size() - cb > exp_q.size()) ? (cap.size() - cb - exp_q.size()) : 0;

        check({name, "_count"},   64'(cap.size() - cb), 64'(v.exp_n));
        check({name, "_eols"},    64'(neol), 64'(v.exp_eols));
        check({name, "_eofs"},    64'(neof), (v.exp_n > 0) ? 64'd1 : 64'd0);
        check({name, "_vs_o"},    64'(vs_cnt - vb), 64'd1);
        check({name, "_cfg_err"}, 64'(bus.cfg_err_o), 64'(v.exp_err));
        check({name, "_latency"}, 64'(lat_err - lb), 64'd0);
        check({name, "_idle"},    64'(idle_err - ib), 64'd0);
        check({name, "_stream"},  64'(mism), 64'd0);
        if (v.exp_n > 0) begin
            check({name, "_first"},    64'(cap[cb].data), 64'(v.exp_first));
            check({name, "_eof_data"}, 64'(eof_data), 64'(v.exp_eof));
        end
    endtask

    frame_vec_t tab[8];
    frame_vec_t v_sx0;
    int         cb, vb;

    initial begin
        tab[0] = '{0, 16, 0, 8, 0, 0, 128, 24'h000000, 24'h00700F, 8, 1'b0};
        tab[1] = '{4, 10, 2, 5, 0, 0,  18, 24'h002004, 24'h004009, 3, 1'b0};
        tab[2] = '{3, 12, 1, 8, 1, 2,  10, 24'h001003, 24'h00500B, 2, 1'b0};
        tab[3] = '{0, 20, 0, 8, 0, 0,   0, 24'h000000, 24'h000000, 0, 1'b1};
        tab[4] = '{1,  3, 6, 8, 0, 0,   4, 24'h006001, 24'h007002, 2, 1'b0};
        tab[5] = '{15, 16, 7, 8, 3, 3,  1, 24'h00700F, 24'h00700F, 1, 1'b0};
        tab[6] = '{2,  5, 4, 4, 0, 0,   0, 24'h000000, 24'h000000, 0, 1'b1};
        tab[7] = '{0, 16, 0, 8, 3, 3,   2, 24'h000000, 24'h000008, 1, 1'b0};
        v_sx0  = '{0, 10, 2, 5, 0, 0,  30, 24'h002000, 24'h004009, 3, 1'b0};

        bus.vs_i = 1'b0; bus.de_i = 1'b0; bus.data_i = '0;
        set_cfg(tab[0]);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs",
              64'({bus.vs_o, bus.de_o, bus.eol_o, bus.eof_o, bus.cfg_err_o, bus.data_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Input ignored before the first frame edge
        cb = cap.size(); vb = vs_cnt;
        repeat (5) drive(1'b0, 1'b1, 24'h0F0F0F);
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("idle_ignored", 64'(cap.size() - cb + vs_cnt - vb), 64'd0);

        for (int i = 0; i < 8; i++) run_frame(tab[i], $sformatf("frame%0d", i), -1, 0);

        // Mid-frame start_x rewrite, then the new value takes effect
        run_frame(tab[1], "midcfg", 20, 0);
        run_frame(v_sx0, "newcfg", -1, 0);

        // Restart in the middle of a frame, edge lands on an in-window pixel
        drive(1'b0, 1'b0, '0);
        set_cfg(tab[0]);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        for (int x = 0; x < 10; x++) drive(1'b0, 1'b1, pix(0, x));
        run_frame(tab[0], "restart", -1, 0);

        // Asynchronous reset at pixel 50 of a full frame
        drive(1'b0, 1'b0, '0);
        set_cfg(tab[0]);
        drive(1'b1, 1'b0, '0);
        drive(1'b0, 1'b0, '0);
        for (int p = 0; p <= 50; p++) drive(1'b0, 1'b1, pix(p / H, p % H));
        #2;
        check("pre_rst_de", 64'(bus.de_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_outputs",
              64'({bus.vs_o, bus.de_o, bus.eol_o, bus.eof_o, bus.cfg_err_o, bus.data_o}), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cb = cap.size(); vb = vs_cnt;
        for (int p = 51; p < H * V; p++) drive(1'b0, 1'b1, pix(p / H, p % H));
        drive(1'b0, 1'b0, '0);
        @(negedge clk);
        check("post_rst_silent", 64'(cap.size() - cb), 64'd0);
        check("post_rst_no_vs",  64'(vs_cnt - vb), 64'd0);
        run_frame(tab[0], "after_rst", -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
